jtframe_sdram_sched: RTL and testbench

Four-slot request scheduler sharing the single word-read port of the SDRAM controller among game ROM clients (CPU, char, scroll, object). It sits between the core's ROM fetch logic and `jtframe_sdram`. Each slot has a one-word cache so repeated reads of the same address do not reach the SDRAM. Grants are round-robin. All traffic stops while a ROM download is in progress.

---
 rtl/jtframe_sdram_sched_if.sv | 59 +++++
 rtl/jtframe_sdram_sched.sv | 191 +++++++++++++++++++
 tb/tb_jtframe_sdram_sched.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/jtframe_sdram_sched_if.sv
// jtframe_sdram_sched_if
// Bundles the four ROM client slots and the word-read port of the SDRAM
// controller that jtframe_sdram_sched sits between.
//   slotN_cs/slotN_addr   : client read request (level held) and word address
//   slotN_ok/slotN_dout   : cached data valid for the current address, and the data
//   sdram_req/sdram_addr  : request and word address towards the controller
//   sdram_ack/data_rdy    : controller address-accepted and read-data-valid pulses
//   data_read             : controller read data
//   downloading           : ROM download in progress
//   refresh_ok            : scheduler idle, controller may refresh
// Modports: slave is the scheduler, master is the environment around it
// (clients plus controller).
interface jtframe_sdram_sched_if;
  logic        downloading;
  logic        slot0_cs;
  logic        slot1_cs;
  logic        slot2_cs;
  logic        slot3_cs;
  logic [21:0] slot0_addr;
  logic [21:0] slot1_addr;
  logic [21:0] slot2_addr;
  logic [21:0] slot3_addr;
  logic        slot0_ok;
  logic        slot1_ok;
  logic        slot2_ok;
  logic        slot3_ok;
  logic [15:0] slot0_dout;
  logic [15:0] slot1_dout;
  logic [15:0] slot2_dout;
  logic [15:0] slot3_dout;
  logic        sdram_req;
  logic [21:0] sdram_addr;
  logic        sdram_ack;
  logic        data_rdy;
  logic [15:0] data_read;
  logic        refresh_ok;

  modport slave (
    input  downloading,
    input  slot0_cs, slot1_cs, slot2_cs, slot3_cs,
    input  slot0_addr, slot1_addr, slot2_addr, slot3_addr,
    output slot0_ok, slot1_ok, slot2_ok, slot3_ok,
    output slot0_dout, slot1_dout, slot2_dout, slot3_dout,
    output sdram_req, sdram_addr,
    input  sdram_ack, data_rdy, data_read,
    output refresh_ok
  );

  modport master (
    output downloading,
    output slot0_cs, slot1_cs, slot2_cs, slot3_cs,
    output slot0_addr, slot1_addr, slot2_addr, slot3_addr,
    input  slot0_ok, slot1_ok, slot2_ok, slot3_ok,
    input  slot0_dout, slot1_dout, slot2_dout, slot3_dout,
    input  sdram_req, sdram_addr,
    output sdram_ack, data_rdy, data_read,
    input  refresh_ok
  );
endinterface

// File: rtl/jtframe_sdram_sched.sv
// jtframe_sdram_sched
// Shares the single word-read port of the SDRAM controller among four ROM
// clients. Each slot keeps a one-word cache (valid/address/data); a slot whose
// current address matches its cache sees ok immediately, otherwise it becomes
// pending and is granted round-robin. A ROM download flushes every cache and
// blocks new grants, while an already granted transaction still completes.
// Ports:
//   clk  : system clock, shared with the SDRAM controller
//   rst  : synchronous active-high reset
//   bus  : jtframe_sdram_sched_if.slave (slot requests, controller handshake)
// Parameters: SLOTn_OFFSET word offset added to the address of slot n (1..3).
module jtframe_sdram_sched #(
  parameter logic [21:0] SLOT1_OFFSET = 22'h0,
  parameter logic [21:0] SLOT2_OFFSET = 22'h0,
  parameter logic [21:0] SLOT3_OFFSET = 22'h0
) (
  input logic                  clk,
  input logic                  rst,
  jtframe_sdram_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DATA = 2'd2
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [1:0]  gslot_r, gslot_nxt_s;
  logic [21:0] gaddr_r, gaddr_nxt_s;
  logic [1:0]  last_grant_r, last_grant_nxt_s;
  logic        sdram_req_r, sdram_req_nxt_s;
  logic [21:0] sdram_addr_r, sdram_addr_nxt_s;
  logic        cache_we_s;

  logic [3:0]  cvalid_r;
  logic [21:0] caddr_r [4];
  logic [15:0] cdata_r [4];

  logic [3:0]  cs_s;
  logic [21:0] addr_s [4];
  logic [3:0]  hit_s;
  logic [3:0]  pending_s;
  logic        found_s;
  logic [1:0]  sel_s;

  // Word offset applied to the address of the selected slot; slot 0 has none
  function automatic logic [21:0] slot_offset(input logic [1:0] slot);
    logic [21:0] off;
    case (slot)
      2'd1:    off = SLOT1_OFFSET;
      2'd2:    off = SLOT2_OFFSET;
      2'd3:    off = SLOT3_OFFSET;
      default: off = 22'h0;
    endcase
    return off;
  endfunction

  assign cs_s      = {bus.slot3_cs, bus.slot2_cs, bus.slot1_cs, bus.slot0_cs};
  assign addr_s[0] = bus.slot0_addr;
  assign addr_s[1] = bus.slot1_addr;
  assign addr_s[2] = bus.slot2_addr;
  assign addr_s[3] = bus.slot3_addr;

  // Cache lookup: a hit needs a valid entry holding exactly the current address
  always_comb begin
    hit_s     = 4'b0000;
    pending_s = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      hit_s[i]     = cvalid_r[i] && (caddr_r[i] == addr_s[i]);
      pending_s[i] = cs_s[i] && !hit_s[i];
    end
  end

  // Round-robin search starting after the last granted slot (i=4 wraps back to it)
  always_comb begin
    logic [1:0] cand;
    found_s = 1'b0;
    sel_s   = 2'd0;
    cand    = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      cand    = last_grant_r + i[1:0];
      sel_s   = (!found_s && pending_s[cand]) ? cand : sel_s;
      found_s = found_s || pending_s[cand];
    end
  end

  // Next-state and registered-output logic of the request handshake
  always_comb begin
    state_nxt_s      = state_r;
    gslot_nxt_s      = gslot_r;
    gaddr_nxt_s      = gaddr_r;
    last_grant_nxt_s = last_grant_r;
    sdram_req_nxt_s  = sdram_req_r;
    sdram_addr_nxt_s = sdram_addr_r;
    cache_we_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (!bus.downloading && found_s) begin
          gslot_nxt_s      = sel_s;
          gaddr_nxt_s      = addr_s[sel_s];
          // 22-bit sum, wraps modulo 2^22
          sdram_addr_nxt_s = addr_s[sel_s] + slot_offset(sel_s);
          sdram_req_nxt_s  = 1'b1;
          last_grant_nxt_s = sel_s;
          state_nxt_s      = WAIT_ACK;
        end else begin
          sdram_req_nxt_s  = 1'b0;
        end
      end
      WAIT_ACK: begin
        // data_rdy here is ignored; the controller always sends it after the ack
        if (bus.sdram_ack) begin
          sdram_req_nxt_s = 1'b0;
          state_nxt_s     = WAIT_DATA;
        end else begin
          sdram_req_nxt_s = 1'b1;
        end
      end
      WAIT_DATA: begin
        if (bus.data_rdy) begin
          cache_we_s  = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_DATA;
        end
      end
      default: begin
        sdram_req_nxt_s = 1'b0;
        state_nxt_s     = IDLE;
      end
    endcase
  end

  // State, grant bookkeeping and controller-facing registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      gslot_r      <= 2'd0;
      gaddr_r      <= 22'h0;
      last_grant_r <= 2'd3;
      sdram_req_r  <= 1'b0;
      sdram_addr_r <= 22'h0;
    end else begin
      state_r      <= state_nxt_s;
      gslot_r      <= gslot_nxt_s;
      gaddr_r      <= gaddr_nxt_s;
      last_grant_r <= last_grant_nxt_s;
      sdram_req_r  <= sdram_req_nxt_s;
      sdram_addr_r <= sdram_addr_nxt_s;
    end
  end

  // Per-slot caches: the entry stores the granted address even if the slot moved
  // on, so a changed address simply misses again. Downloading flushes every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cvalid_r <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        caddr_r[i] <= 22'h0;
        cdata_r[i] <= 16'h0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        cvalid_r[i] <= bus.downloading ? 1'b0 :
                       (cache_we_s && (gslot_r == i[1:0])) ? 1'b1 : cvalid_r[i];
        if (cache_we_s && (gslot_r == i[1:0])) begin
          caddr_r[i] <= gaddr_r;
          cdata_r[i] <= bus.data_read;
        end else begin
          caddr_r[i] <= caddr_r[i];
          cdata_r[i] <= cdata_r[i];
        end
      end
    end
  end

  assign bus.slot0_ok   = cs_s[0] && hit_s[0];
  assign bus.slot1_ok   = cs_s[1] && hit_s[1];
  assign bus.slot2_ok   = cs_s[2] && hit_s[2];
  assign bus.slot3_ok   = cs_s[3] && hit_s[3];
  assign bus.slot0_dout = cdata_r[0];
  assign bus.slot1_dout = cdata_r[1];
  assign bus.slot2_dout = cdata_r[2];
  assign bus.slot3_dout = cdata_r[3];
  assign bus.sdram_req  = sdram_req_r;
  assign bus.sdram_addr = sdram_addr_r;
  // Downloading keeps the scheduler quiet, so refresh is allowed even with cs high
  assign bus.refresh_ok = (state_r == IDLE) && (bus.downloading || (pending_s == 4'b0000));

endmodule

// File: tb/tb_jtframe_sdram_sched.sv
// tb_jtframe_sdram_sched
// Directed bench for jtframe_sdram_sched with SLOT1_OFFSET=22'h100 and
// SLOT2_OFFSET=22'h3F_FFF0 (wrapping offset); the bench plays the controller.
module tb_jtframe_sdram_sched;
  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  jtframe_sdram_sched_if bus ();

  jtframe_sdram_sched #(
    .SLOT1_OFFSET (22'h000100),
    .SLOT2_OFFSET (22'h3FFFF0),
    .SLOT3_OFFSET (22'h000000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a request, then check the address presented
  task automatic expect_req(input string tag, input logic [21:0] exp_addr);
    int n;
    n = 0;
    while (bus.sdram_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_req"}, {31'd0, bus.sdram_req}, 32'd1);
    chk({tag, "_addr"}, {10'd0, bus.sdram_addr}, {10'd0, exp_addr});
  endtask

  task automatic ack_pulse(input string tag);
    bus.sdram_ack = 1'b1;
    tick();
    bus.sdram_ack = 1'b0;
    chk({tag, "_req_drop"}, {31'd0, bus.sdram_req}, 32'd0);
  endtask

  task automatic data_pulse(input logic [15:0] d);
    bus.data_rdy  = 1'b1;
    bus.data_read = d;
    tick();
    bus.data_rdy  = 1'b0;
    bus.data_read = 16'h0;
  endtask

  initial begin
    logic seen_req;
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.downloading = 1'b0;
    bus.slot0_cs = 1'b0; bus.slot1_cs = 1'b0; bus.slot2_cs = 1'b0; bus.slot3_cs = 1'b0;
    bus.slot0_addr = 22'h0; bus.slot1_addr = 22'h0; bus.slot2_addr = 22'h0; bus.slot3_addr = 22'h0;
    bus.sdram_ack = 1'b0;
    bus.data_rdy  = 1'b0;
    bus.data_read = 16'h0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_req", {31'd0, bus.sdram_req}, 32'd0);
    chk("rst_addr", {10'd0, bus.sdram_addr}, 32'd0);
    chk("rst_ok0", {31'd0, bus.slot0_ok}, 32'd0);
    chk("rst_dout0", {16'd0, bus.slot0_dout}, 32'd0);
    chk("rst_refresh", {31'd0, bus.refresh_ok}, 32'd1);

    // Slot 0 miss at 22'h100, slow ack and data
    bus.slot0_cs = 1'b1; bus.slot0_addr = 22'h100;
    #1;
    chk("miss_refresh", {31'd0, bus.refresh_ok}, 32'd0);
    tick();
    chk("miss_req1", {31'd0, bus.sdram_req}, 32'd1);
    expect_req("s0", 22'h100);
    tick();
    chk("s0_req_hold", {31'd0, bus.sdram_req}, 32'd1);
    ack_pulse("s0");
    tick();
    tick();
    chk("s0_ok_wait", {31'd0, bus.slot0_ok}, 32'd0);
    data_pulse(16'hBEEF);
    chk("s0_ok", {31'd0, bus.slot0_ok}, 32'd1);
    chk("s0_dout", {16'd0, bus.slot0_dout}, 32'h0000BEEF);
    chk("s0_refresh", {31'd0, bus.refresh_ok}, 32'd1);
    seen_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen_req = seen_req | bus.sdram_req;
    end
    chk("s0_hit_noreq", {31'd0, seen_req}, 32'd0);
    bus.slot0_cs = 1'b0;

    // Slot 2 offset wraps: 22'h20 + 22'h3F_FFF0 = 22'h10
    bus.slot2_cs = 1'b1; bus.slot2_addr = 22'h20;
    expect_req("s2wrap", 22'h000010);
    ack_pulse("s2wrap");
    data_pulse(16'h2222);
    chk("s2_ok", {31'd0, bus.slot2_ok}, 32'd1);
    chk("s2_dout", {16'd0, bus.slot2_dout}, 32'h00002222);
    bus.slot2_cs = 1'b0;

    // Slot 1 offset 22'h100: 22'h50 -> 22'h150
    bus.slot1_cs = 1'b1; bus.slot1_addr = 22'h50;
    expect_req("s1off", 22'h000150);
    ack_pulse("s1off");
    data_pulse(16'h1111);
    chk("s1_ok", {31'd0, bus.slot1_ok}, 32'd1);
    bus.slot1_cs = 1'b0;

    // Round robin from reset: 0,1 then slot1 re-misses and waits for 2,3
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.slot0_cs = 1'b1; bus.slot0_addr = 22'h200;
    bus.slot1_cs = 1'b1; bus.slot1_addr = 22'h201;
    bus.slot2_cs = 1'b1; bus.slot2_addr = 22'h202;
    bus.slot3_cs = 1'b1; bus.slot3_addr = 22'h203;
    expect_req("rr0", 22'h000200);
    ack_pulse("rr0");
    data_pulse(16'hA000);
    expect_req("rr1", 22'h000301);
    ack_pulse("rr1");
    data_pulse(16'hA001);
    bus.slot1_addr = 22'h211;
    expect_req("rr2", 22'h0001F2);
    ack_pulse("rr2");
    data_pulse(16'hA002);
    expect_req("rr3", 22'h000203);
    ack_pulse("rr3");
    data_pulse(16'hA003);
    expect_req("rr1b", 22'h000311);
    ack_pulse("rr1b");
    data_pulse(16'hA011);
    chk("rr_ok0", {31'd0, bus.slot0_ok}, 32'd1);
    chk("rr_ok1", {31'd0, bus.slot1_ok}, 32'd1);
    chk("rr_dout1", {16'd0, bus.slot1_dout}, 32'h0000A011);
    chk("rr_ok2", {31'd0, bus.slot2_ok}, 32'd1);
    chk("rr_dout3", {16'd0, bus.slot3_dout}, 32'h0000A003);

    // Slot 3 address changes while its data is outstanding
    bus.slot0_cs = 1'b0; bus.slot1_cs = 1'b0; bus.slot2_cs = 1'b0;
    bus.slot3_addr = 22'h5;
    expect_req("s3a", 22'h000005);
    ack_pulse("s3a");
    bus.slot3_addr = 22'h6;
    data_pulse(16'h5555);
    chk("s3_stale_ok", {31'd0, bus.slot3_ok}, 32'd0);
    expect_req("s3b", 22'h000006);
    ack_pulse("s3b");
    data_pulse(16'h6666);
    chk("s3_ok", {31'd0, bus.slot3_ok}, 32'd1);
    chk("s3_dout", {16'd0, bus.slot3_dout}, 32'h00006666);

    // Download starts while slot 0 data is outstanding
    bus.slot0_cs = 1'b1; bus.slot0_addr = 22'h400;
    expect_req("dl", 22'h000400);
    ack_pulse("dl");
    bus.downloading = 1'b1;
    data_pulse(16'h7777);
    chk("dl_ok0", {31'd0, bus.slot0_ok}, 32'd0);
    seen_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen_req = seen_req | bus.sdram_req;
    end
    chk("dl_noreq", {31'd0, seen_req}, 32'd0);
    chk("dl_refresh", {31'd0, bus.refresh_ok}, 32'd1);
    chk("dl_ok3_flushed", {31'd0, bus.slot3_ok}, 32'd0);
    bus.downloading = 1'b0;
    expect_req("post_dl3", 22'h000006);
    ack_pulse("post_dl3");
    data_pulse(16'h6666);
    expect_req("post_dl0", 22'h000400);
    ack_pulse("post_dl0");
    data_pulse(16'h7777);
    chk("post_dl_ok0", {31'd0, bus.slot0_ok}, 32'd1);
    chk("post_dl_ok3", {31'd0, bus.slot3_ok}, 32'd1);

    // Reset while waiting for the ack
    bus.slot1_cs = 1'b1; bus.slot1_addr = 22'h500;
    expect_req("rst_wa", 22'h000600);
    rst = 1'b1;
    tick();
    chk("rstwa_req", {31'd0, bus.sdram_req}, 32'd0);
    chk("rstwa_addr", {10'd0, bus.sdram_addr}, 32'd0);
    chk("rstwa_ok0", {31'd0, bus.slot0_ok}, 32'd0);
    chk("rstwa_ok3", {31'd0, bus.slot3_ok}, 32'd0);
    bus.slot0_cs = 1'b0; bus.slot1_cs = 1'b0; bus.slot2_cs = 1'b0; bus.slot3_cs = 1'b0;
    #1;
    chk("rstwa_refresh", {31'd0, bus.refresh_ok}, 32'd1);
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
